// File: rtl/riscv_mem_map_pkg.sv
// Address map shared by the data-side memory system: default bases, I/O
// register offsets and the registered read-select encoding.
package riscv_mem_map_pkg;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DEFAULT_IO_BASE   = 32'h0000_7f00;

    localparam logic [7:0] IO_LED    = 8'h00;
    localparam logic [7:0] IO_SW     = 8'h04;
    localparam logic [7:0] IO_SEG    = 8'h08;
    localparam logic [7:0] IO_TIMER  = 8'h0c;
    localparam logic [7:0] IO_CYCLES = 8'h10;
    localparam logic [7:0] IO_STATUS = 8'h14;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DATA = 2'd1,
        SEL_IO   = 2'd2
    } mem_sel_t;

endpackage

// File: rtl/riscv_data_mem_io_if.sv
// MEM-stage data bus between the core and the data memory system.
interface riscv_data_mem_io_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;

    modport master (output MemRead, MemWrite, dAddress, dWriteData, input dReadData);
    modport slave  (input MemRead, MemWrite, dAddress, dWriteData, output dReadData);
endinterface

// File: rtl/riscv_data_bram.sv
// Single-port word-addressed data RAM: synchronous, write-first read port
// whose output only changes when a read is enabled.
module riscv_data_bram #(
    parameter int DATA_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic                          en,
    input  logic [$clog2(DATA_WORDS)-1:0] addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);
    logic [31:0] mem_r [DATA_WORDS];

    // Array write and enabled synchronous read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (en) begin
            rdata <= we ? wdata : mem_r[addr];
        end
    end
endmodule

// File: rtl/riscv_data_mem_io.sv
// Data-side memory system: decodes MEM-stage accesses to data BRAM, the
// memory-mapped I/O registers, or an error slot, and returns 1-cycle load data.
module riscv_data_mem_io
    import riscv_mem_map_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
    parameter int          DATA_WORDS  = 1024,
    parameter logic [31:0] IO_BASE     = DEFAULT_IO_BASE,
    parameter int          CLK_FREQ_HZ = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    riscv_data_mem_io_if.slave  bus,
    input  logic [15:0]         sw,
    output logic [15:0]         led,
    output logic [31:0]         seg_value,
    output logic                bus_err
);
    localparam int          ADDR_W     = $clog2(DATA_WORDS);
    localparam logic [31:0] DATA_BYTES = 32'(4 * DATA_WORDS);
    localparam logic [31:0] TICK_LAST  = 32'(CLK_FREQ_HZ / 1000 - 1);

    logic [31:0] offset_s, io_rdata_s, io_rdata_r, bram_q_s;
    logic [31:0] timer_r, presc_r, cycles_r, seg_r;
    logic [15:0] led_r, sync1_r, sync2_r;
    logic [7:0]  io_off_s;
    logic        access_s, data_hit_s, io_hit_s, misalign_s, both_s, err_s;
    logic        wr_ok_s, bram_we_s, bram_en_s, io_we_s, tick_s, bus_err_r;
    mem_sel_t    sel_r, sel_next_s;

    assign offset_s   = bus.dAddress - DATA_BASE;
    assign io_off_s   = bus.dAddress[7:0];
    assign access_s   = bus.MemRead | bus.MemWrite;
    assign data_hit_s = offset_s < DATA_BYTES;
    assign io_hit_s   = bus.dAddress[31:8] == IO_BASE[31:8];
    assign misalign_s = bus.dAddress[1:0] != 2'b00;
    assign both_s     = bus.MemRead & bus.MemWrite;
    assign err_s      = access_s & (misalign_s | ~(data_hit_s | io_hit_s) | both_s);
    // A combined read+write still performs the write; only alignment and mapping gate it.
    assign wr_ok_s    = bus.MemWrite & ~misalign_s & ~rst;
    assign bram_we_s  = wr_ok_s & data_hit_s;
    assign bram_en_s  = bus.MemRead & ~bus.MemWrite & ~misalign_s & data_hit_s & ~rst;
    assign io_we_s    = wr_ok_s & io_hit_s;
    assign tick_s     = presc_r == TICK_LAST;

    riscv_data_bram #(.DATA_WORDS(DATA_WORDS)) u_bram (
        .clk   (clk),
        .we    (bram_we_s),
        .en    (bram_en_s),
        .addr  (offset_s[ADDR_W+1:2]),
        .wdata (bus.dWriteData),
        .rdata (bram_q_s)
    );

    // I/O read data and read-select decode for the current access.
    always_comb begin
        io_rdata_s = 32'h0000_0000;
        sel_next_s = SEL_NONE;
        case (io_off_s)
            IO_LED:    io_rdata_s = {16'h0000, led_r};
            IO_SW:     io_rdata_s = {16'h0000, sync2_r};
            IO_SEG:    io_rdata_s = seg_r;
            IO_TIMER:  io_rdata_s = timer_r;
            IO_CYCLES: io_rdata_s = cycles_r;
            IO_STATUS: io_rdata_s = {31'h0000_0000, bus_err_r};
            default:   io_rdata_s = 32'h0000_0000;
        endcase
        if (err_s) begin
            sel_next_s = SEL_NONE;
        end else if (data_hit_s) begin
            sel_next_s = SEL_DATA;
        end else if (io_hit_s) begin
            sel_next_s = SEL_IO;
        end else begin
            sel_next_s = SEL_NONE;
        end
    end

    // I/O registers, counters, synchronizer, error flag and read-select state.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r      <= 16'h0000;
            seg_r      <= 32'h0000_0000;
            timer_r    <= 32'h0000_0000;
            presc_r    <= 32'h0000_0000;
            cycles_r   <= 32'h0000_0000;
            sync1_r    <= 16'h0000;
            sync2_r    <= 16'h0000;
            bus_err_r  <= 1'b0;
            sel_r      <= SEL_NONE;
            io_rdata_r <= 32'h0000_0000;
        end else begin
            sync1_r  <= sw;
            sync2_r  <= sync1_r;
            cycles_r <= cycles_r + 32'd1;
            // A CPU load of the timer overrides a coincident tick.
            if (io_we_s && io_off_s == IO_TIMER) begin
                timer_r <= bus.dWriteData;
                presc_r <= 32'h0000_0000;
            end else if (tick_s) begin
                timer_r <= timer_r + 32'd1;
                presc_r <= 32'h0000_0000;
            end else begin
                presc_r <= presc_r + 32'd1;
            end
            if (io_we_s && io_off_s == IO_LED) begin
                led_r <= bus.dWriteData[15:0];
            end
            if (io_we_s && io_off_s == IO_SEG) begin
                seg_r <= bus.dWriteData;
            end
            if (err_s) begin
                bus_err_r <= 1'b1;
            end else if (io_we_s && io_off_s == IO_STATUS && bus.dWriteData[0]) begin
                bus_err_r <= 1'b0;
            end
            if (bus.MemRead) begin
                sel_r      <= sel_next_s;
                io_rdata_r <= io_rdata_s;
            end
        end
    end

    // Output mux is driven only from registered state.
    always_comb begin
        bus.dReadData = 32'h0000_0000;
        case (sel_r)
            SEL_DATA: bus.dReadData = bram_q_s;
            SEL_IO:   bus.dReadData = io_rdata_r;
            default:  bus.dReadData = 32'h0000_0000;
        endcase
    end

    assign led       = led_r;
    assign seg_value = seg_r;
    assign bus_err   = bus_err_r;
endmodule

// File: tb/tb_riscv_data_mem_io.sv
// Directed bench for riscv_data_mem_io with a 4-cycle millisecond tick.
module tb_riscv_data_mem_io;
    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic [15:0] led;
    logic [31:0] seg_value;
    logic        bus_err;
    logic [31:0] rd_val;
    logic [31:0] c1;
    logic [31:0] c2;
    int          n_tests;
    int          n_fail;

    riscv_data_mem_io_if bus_if ();

    riscv_data_mem_io #(.CLK_FREQ_HZ(4000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .sw        (sw),
        .led       (led),
        .seg_value (seg_value),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.MemWrite   = 1'b1;
        bus_if.dAddress   = addr;
        bus_if.dWriteData = data;
        @(negedge clk);
        bus_if.MemWrite   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus_if.MemRead  = 1'b1;
        bus_if.dAddress = addr;
        @(negedge clk);
        bus_if.MemRead  = 1'b0;
        data = bus_if.dReadData;
    endtask

    task automatic rw_both(input logic [31:0] addr, input logic [31:0] data);
        bus_if.MemRead    = 1'b1;
        bus_if.MemWrite   = 1'b1;
        bus_if.dAddress   = addr;
        bus_if.dWriteData = data;
        @(negedge clk);
        bus_if.MemRead    = 1'b0;
        bus_if.MemWrite   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk = 1'b0;
        rst = 1'b1;
        sw  = 16'h0000;
        bus_if.MemRead    = 1'b0;
        bus_if.MemWrite   = 1'b0;
        bus_if.dAddress   = 32'h0000_0000;
        bus_if.dWriteData = 32'h0000_0000;
        idle(3);
        check("rst_rdata", bus_if.dReadData, 32'h0000_0000);
        check("rst_led", {16'h0000, led}, 32'h0000_0000);
        check("rst_seg", seg_value, 32'h0000_0000);
        check("rst_err", {31'h0, bus_err}, 32'h0000_0000);
        rst = 1'b0;

        // Millisecond timer: 40 cycles, wrap, and write coincident with a tick
        idle(40);
        rd(32'h0000_7f0c, rd_val);  check("timer_40cyc", rd_val, 32'd10);
        wr(32'h0000_7f0c, 32'hFFFF_FFFF);
        rd(32'h0000_7f0c, rd_val);  check("timer_load", rd_val, 32'hFFFF_FFFF);
        idle(3);
        rd(32'h0000_7f0c, rd_val);  check("timer_wrap", rd_val, 32'h0000_0000);
        idle(2);
        wr(32'h0000_7f0c, 32'h0000_1234);
        rd(32'h0000_7f0c, rd_val);  check("timer_tick_wr", rd_val, 32'h0000_1234);

        // Data BRAM write then immediate read
        wr(32'h1001_0010, 32'hDEAD_BEEF);
        rd(32'h1001_0010, rd_val);  check("bram_rw", rd_val, 32'hDEAD_BEEF);
        check("bram_err", {31'h0, bus_err}, 32'h0000_0000);

        // LED, switches, seven-segment, unused I/O offset
        wr(32'h0000_7f00, 32'h0001_A5A5);
        check("led_pin", {16'h0000, led}, 32'h0000_A5A5);
        rd(32'h0000_7f00, rd_val);  check("led_rd", rd_val, 32'h0000_A5A5);
        sw = 16'h1234;
        idle(3);
        rd(32'h0000_7f04, rd_val);  check("sw_rd", rd_val, 32'h0000_1234);
        wr(32'h0000_7f04, 32'hFFFF_FFFF);
        rd(32'h0000_7f04, rd_val);  check("sw_ro", rd_val, 32'h0000_1234);
        wr(32'h0000_7f08, 32'hCAFE_F00D);
        check("seg_pin", seg_value, 32'hCAFE_F00D);
        rd(32'h0000_7f08, rd_val);  check("seg_rd", rd_val, 32'hCAFE_F00D);
        rd(32'h0000_7f40, rd_val);  check("io_hole_rd", rd_val, 32'h0000_0000);
        check("io_hole_err", {31'h0, bus_err}, 32'h0000_0000);

        // Cycle counter advances by one per clock
        rd(32'h0000_7f10, c1);
        idle(5);
        rd(32'h0000_7f10, c2);
        check("cycles_delta", c2 - c1, 32'd6);

        // Misaligned, status clear, unmapped
        rd(32'h1001_0002, rd_val);  check("misalign_rd", rd_val, 32'h0000_0000);
        check("misalign_err", {31'h0, bus_err}, 32'h0000_0001);
        wr(32'h0000_7f14, 32'h0000_0001);
        check("status_clr", {31'h0, bus_err}, 32'h0000_0000);
        wr(32'h2000_0000, 32'h0000_0077);
        check("unmapped_err", {31'h0, bus_err}, 32'h0000_0001);
        rd(32'h1001_0010, rd_val);  check("unmapped_nowr", rd_val, 32'hDEAD_BEEF);
        wr(32'h0000_7f14, 32'h0000_0001);

        // Top and one-past-top of the data window
        wr(32'h1001_0FFC, 32'h600D_F00D);
        rd(32'h1001_0FFC, rd_val);  check("bram_top", rd_val, 32'h600D_F00D);
        check("bram_top_err", {31'h0, bus_err}, 32'h0000_0000);
        wr(32'h1001_1000, 32'h0000_0001);
        check("bram_past_err", {31'h0, bus_err}, 32'h0000_0001);
        wr(32'h0000_7f14, 32'h0000_0001);
        check("status_clr2", {31'h0, bus_err}, 32'h0000_0000);

        // Simultaneous read and write
        rd(32'h1001_0010, rd_val);
        rw_both(32'h1001_0020, 32'h0000_0005);
        check("both_rdata", bus_if.dReadData, 32'h0000_0000);
        check("both_err", {31'h0, bus_err}, 32'h0000_0001);
        rd(32'h1001_0020, rd_val);  check("both_wr", rd_val, 32'h0000_0005);
        rw_both(32'h0000_7f14, 32'h0000_0001);
        check("err_wins", {31'h0, bus_err}, 32'h0000_0001);
        rd(32'h0000_7f14, rd_val);  check("status_rd", rd_val, 32'h0000_0001);
        wr(32'h0000_7f14, 32'h0000_0001);

        // Reset mid-sequence with a coincident write that must be dropped
        wr(32'h0000_7f00, 32'h0000_FFFF);
        check("led_ff", {16'h0000, led}, 32'h0000_FFFF);
        rd(32'h2000_0000, rd_val);
        rd(32'h1001_0010, rd_val);
        rst = 1'b1;
        bus_if.MemWrite   = 1'b1;
        bus_if.dAddress   = 32'h1001_0010;
        bus_if.dWriteData = 32'h0000_0000;
        @(negedge clk);
        bus_if.MemWrite = 1'b0;
        check("rst2_led", {16'h0000, led}, 32'h0000_0000);
        check("rst2_err", {31'h0, bus_err}, 32'h0000_0000);
        check("rst2_rdata", bus_if.dReadData, 32'h0000_0000);
        rst = 1'b0;
        rd(32'h0000_7f10, rd_val);  check("rst2_cycles", rd_val, 32'h0000_0000);
        rd(32'h0000_7f0c, rd_val);  check("rst2_timer", rd_val, 32'h0000_0000);
        rd(32'h1001_0010, rd_val);  check("rst2_bram", rd_val, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
